// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and GF(2^8) helpers.
// inv_mix_column/inv_mix_columns serve the INV_KEY_EXPANSION_EQUIV_EN output path.
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SUB_WORD = 2'd1,
    S_EXPAND   = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam int         NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  // Divides by x in GF(2^8); walks the round constants backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] n);
    return n[0] ? (((n ^ 8'h1b) >> 1) | 8'h80) : (n >> 1);
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0]  a  [0:3];
    logic [7:0]  m9 [0:3];
    logic [7:0]  mb [0:3];
    logic [7:0]  md [0:3];
    logic [7:0]  me [0:3];
    logic [7:0]  x2, x4, x8;
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] blk);
    logic [127:0] res;
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      res[127-32*c -: 32] = inv_mix_column(blk[127-32*c -: 32]);
    end
    return res;
  endfunction

endpackage

// File: rtl/sub_word.sv
// 32-bit AES S-box: four byte substitutions computed as GF(2^8) inverse plus affine map.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv_exp;
    logic [7:0] r;
    inv_exp = 8'hfe;
    r       = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (inv_exp[i]) begin
        r = gf_mul(r, a);
      end
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Byte-parallel substitution.
  always_comb begin
    sub = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      sub[8*i +: 8] = sbox(word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: rebuilds round keys 9..0 from the round-10 key, two cycles per round.
// Define INV_KEY_EXPANSION_EQUIV_EN to present keys 1..9 through InvMixColumns (equivalent inverse cipher).
module inv_key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [127:0] key_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [127:0] round_key_o [0:NUM_ROUNDS]
);

  state_e       state_r;
  state_e       state_s;
  logic [3:0]   round_idx_r;
  logic [7:0]   rcon_r;
  logic [31:0]  temp_r;
  logic [127:0] key_r [0:NUM_ROUNDS];
  logic         ready_r;
  logic         valid_r;

  logic [127:0] cur_key_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  sub_s;

  // Split the round key currently being walked back into its four words.
  always_comb begin
    cur_key_s = key_r[round_idx_r];
    w0_s      = cur_key_s[127:96];
    w1_s      = cur_key_s[95:64];
    w2_s      = cur_key_s[63:32];
    w3_s      = cur_key_s[31:0];
  end

  // w3 ^ w2 recovers the previous round's last word, which feeds the S-box.
  sub_word u_sub_word (
    .word (rot_word(w3_s ^ w2_s)),
    .sub  (sub_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (valid_i) begin
          state_s = S_SUB_WORD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SUB_WORD: state_s = S_EXPAND;
      S_EXPAND: begin
        if (round_idx_r == 4'd1) begin
          state_s = S_DONE;
        end else begin
          state_s = S_SUB_WORD;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State and handshake registers; outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == S_IDLE);
      valid_r <= (state_s == S_DONE);
    end
  end

  // Schedule datapath: load, substitute, then recover one round key per pair of cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_idx_r <= 4'd10;
      rcon_r      <= RCON_LAST;
      temp_r      <= 32'h0000_0000;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        key_r[i] <= 128'd0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (valid_i) begin
            key_r[NUM_ROUNDS] <= key_i;
            round_idx_r       <= 4'd10;
            rcon_r            <= RCON_LAST;
          end
        end
        S_SUB_WORD: temp_r <= sub_s;
        S_EXPAND: begin
          key_r[round_idx_r - 4'd1] <= {w0_s ^ temp_r ^ {rcon_r, 24'h00_0000},
                                        w1_s ^ w0_s, w2_s ^ w1_s, w3_s ^ w2_s};
          round_idx_r               <= round_idx_r - 4'd1;
          rcon_r                    <= inv_xtime(rcon_r);
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef INV_KEY_EXPANSION_EQUIV_EN
  // Inner round keys leave through InvMixColumns; the recursion above keeps raw keys.
  always_comb begin
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if ((i == 0) || (i == NUM_ROUNDS)) begin
        round_key_o[i] = key_r[i];
      end else begin
        round_key_o[i] = inv_mix_columns(key_r[i]);
      end
    end
  end
`else
  // Raw schedule straight from the key registers.
  always_comb begin
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      round_key_o[i] = key_r[i];
    end
  end
`endif

  assign ready_o = ready_r;
  assign valid_o = valid_r;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Self-checking bench for inv_key_expansion: random cipher keys are forward-expanded by a
// table-driven model and the round-10 key is fed back; all 11 keys plus handshake timing are checked.
module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic [127:0] key_i;
  logic         ready_o;
  logic         valid_o;
  logic [127:0] round_key_o [0:10];

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] SBOX_ROW [0:15] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [79:0] RCON_TAB = 80'h01020408102040801b36;

  inv_key_expansion dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .key_i       (key_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .round_key_o (round_key_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_sbox(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROW[b[7:4]];
    return row[8*(15 - b[3:0]) +: 8];
  endfunction

  function automatic logic [31:0] tb_sub_word(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] tb_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] tb_imc(input logic [127:0] blk);
    logic [127:0] res;
    logic [7:0]   a [0:3];
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = blk[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        res[127-32*c-8*r -: 8] = tb_gf_mul(8'h0e, a[r]) ^ tb_gf_mul(8'h0b, a[(r+1)%4]) ^
                                 tb_gf_mul(8'h0d, a[(r+2)%4]) ^ tb_gf_mul(8'h09, a[(r+3)%4]);
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] expected_out(input int idx, input logic [127:0] raw);
`ifdef INV_KEY_EXPANSION_EQUIV_EN
    if (idx >= 1 && idx <= 9) return tb_imc(raw);
`endif
    return raw;
  endfunction

  // FIPS-197 forward schedule from the cipher key.
  task automatic expand_fwd(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [79:0] rc_tab;
    rc_tab = RCON_TAB;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = tb_sub_word({t[23:0], t[31:24]}) ^ {rc_tab[79-8*(i/4-1) -: 8], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i <= 10; i++) begin
      check_val($sformatf("%s_rk%0d", tag, i), round_key_o[i], expected_out(i, exp_rk[i]));
    end
  endtask

  task automatic start_run(input logic [127:0] k);
    valid_i = 1'b1;
    key_i   = k;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_o) seen = 1'b1;
    end
    if (!seen) check_val("valid_timeout", {127'd0, seen}, 128'd1);
  endtask

  logic [127:0] rk_b [0:10];
  logic [127:0] ck;
  int           n;
  bit           seen_v;

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    key_i   = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", {127'd0, ready_o}, 128'd1);
    check_val("rst_valid", {127'd0, valid_o}, 128'd0);
    for (int i = 0; i <= 10; i++) exp_rk[i] = 128'd0;
    compare_all("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 Appendix A
    expand_fwd(128'h2b7e151628aed2a6abf7158809cf4f3c);
    start_run(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_val("busy_ready", {127'd0, ready_o}, 128'd0);
    wait_valid(n);
    check_val("fips_latency", 128'(n), 128'd20);
    check_val("fips_rk0", round_key_o[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check_val("fips_rk9", round_key_o[9], expected_out(9, 128'hac7766f319fadc2128d12941575c006e));
    compare_all("fips");
    @(posedge clk);
    #1;
    check_val("pulse_end", {127'd0, valid_o}, 128'd0);
    check_val("ready_back", {127'd0, ready_o}, 128'd1);

    // Random round-trips
    for (int k = 0; k < 1000; k++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      expand_fwd(ck);
      start_run(exp_rk[10]);
      wait_valid(n);
      check_val("rand_latency", 128'(n), 128'd20);
      compare_all("rand");
      @(posedge clk);
      #1;
    end

    // valid_i during S_EXPAND of round 5 is ignored
    ck = {$urandom, $urandom, $urandom, $urandom};
    expand_fwd(ck);
    start_run(exp_rk[10]);
    repeat (11) @(posedge clk);
    #1;
    check_val("ign_ready", {127'd0, ready_o}, 128'd0);
    valid_i = 1'b1;
    key_i   = ~exp_rk[10];
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    wait_valid(n);
    check_val("ign_latency", 128'(n), 128'd8);
    compare_all("ign");
    @(posedge clk);
    #1;

    // Reset mid-run aborts
    ck = {$urandom, $urandom, $urandom, $urandom};
    expand_fwd(ck);
    start_run(exp_rk[10]);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_ready", {127'd0, ready_o}, 128'd1);
    check_val("abort_valid", {127'd0, valid_o}, 128'd0);
    for (int i = 0; i <= 10; i++) exp_rk[i] = 128'd0;
    compare_all("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    seen_v = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (valid_o) seen_v = 1'b1;
    end
    check_val("abort_no_valid", {127'd0, seen_v}, 128'd0);
    check_val("abort_idle", {127'd0, ready_o}, 128'd1);
    ck = {$urandom, $urandom, $urandom, $urandom};
    expand_fwd(ck);
    start_run(exp_rk[10]);
    wait_valid(n);
    compare_all("post_abort");
    @(posedge clk);
    #1;

    // valid_i held high across two runs, key changed after the first accept
    ck = {$urandom, $urandom, $urandom, $urandom};
    expand_fwd(ck);
    rk_b = exp_rk;
    ck = {$urandom, $urandom, $urandom, $urandom};
    expand_fwd(ck);
    valid_i = 1'b1;
    key_i   = exp_rk[10];
    @(posedge clk);
    #1;
    key_i = rk_b[10];
    wait_valid(n);
    check_val("held_lat1", 128'(n), 128'd20);
    compare_all("held_a");
    exp_rk = rk_b;
    wait_valid(n);
    valid_i = 1'b0;
    check_val("held_gap", 128'(n), 128'd22);
    compare_all("held_b");
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_key_expansion.md
# inv_key_expansion

- Reverse AES-128 key schedule.
- Loads the final round key (round 10) and iteratively reconstructs round keys 9 down to 0. Output is the full 11-entry schedule.
- Sits on the decryption path next to `key_expansion`. Lets the decryptor start from a stored last-round key without re-running the forward schedule.
- Single `sub_word` per round, two cycles per round, `valid_o` pulse on completion.

## Interface
Parameters: none (AES-128 only; widths fixed by the shared package).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset; one clock; asynchronous, active-low
- valid_i  input  1  load request; sampled only in S_IDLE
- key_i  input  128  round-10 key, {w40,w41,w42,w43}, w40 in [127:96]
- ready_o  output  1  high when in S_IDLE (load will be accepted)
- valid_o  output  1  one-cycle pulse: round_key_o complete
- round_key_o  output  128 x [0:10]  round keys; index 0 = cipher key, index 10 = key_i

## Operation
- FSM states and transitions:
  - S_IDLE → S_SUB_WORD on valid_i, otherwise stay.
  - S_SUB_WORD → S_EXPAND.
  - S_EXPAND → S_DONE if round_idx == 1, otherwise → S_SUB_WORD.
  - S_DONE → S_IDLE.
  - Illegal encoding → S_IDLE.
- Accept (S_IDLE & valid_i):
  - key_reg[10] <= key_i.
  - round_idx <= 10.
  - rcon <= 8'h36.
- Notation: key_reg[round_idx] = {w0,w1,w2,w3}.
- S_SUB_WORD: temp_reg <= SubWord(RotWord(w3 ^ w2)).
- S_EXPAND:
  - key_reg[round_idx-1] <= {w0 ^ temp_reg ^ {rcon,24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2}.
  - round_idx <= round_idx - 1.
  - rcon <= inv_xtime(rcon).
- inv_xtime(n): n[0] ? ((n ^ 8'h1b) >> 1) | 8'h80 : n >> 1.
  - Sequence: 36,1b,80,40,20,10,08,04,02,01.
- All XORs are 32-bit, no carries. round_idx is 4 bits; never leaves 1..10 outside S_IDLE.
- valid_i outside S_IDLE is ignored: no restart, no key overwrite.
- key_reg entries hold their value until overwritten by the next run; they are not cleared on S_DONE → S_IDLE.
- During a run:
  - Entries not yet rewritten show the previous run's values.
  - Consumers must only sample on valid_o.

## Timing
- Reset (async assert, sync release by the system):
  - state = S_IDLE, round_idx = 10, rcon = 8'h36, temp_reg = 0, all key_reg = 0.
  - valid_o = 0, ready_o = 1.
- Latency: valid_i accepted at edge E. valid_o is high during the cycle after edge E+20 (10 × SUB/EXPAND pairs), i.e. 21 cycles of not-ready including S_DONE.
- ready_o is low from edge E through S_DONE. It returns high the cycle after the valid_o pulse.
- Throughput: one schedule per 22 cycles max; back-to-back accept possible in the first S_IDLE cycle.
- valid_i held high continuously: restarts on each S_IDLE cycle. Every run uses the key_i present on that edge.
- Reset mid-run: immediate abort; all registers return to reset values; no valid_o.

## Configuration
- INV_KEY_EXPANSION_EQUIV_EN
  - Defined: round_key_o[1..9] = InvMixColumns(key_reg[1..9]), i.e. Equivalent Inverse Cipher decryption keys, applied combinationally on the output path. round_key_o[0] and [10] are unchanged. Internal recursion always uses raw keys.
  - Undefined: round_key_o = key_reg directly.
- Timing, latency and valid_o are identical in both builds.

## Structure
- Shared package aes_pkg:
  - state_e enum (S_IDLE, S_SUB_WORD, S_EXPAND, S_DONE).
  - NUM_ROUNDS = 10, RCON_LAST = 8'h36.
  - Functions rot_word, xtime, inv_xtime.
  - inv_mix_column (used only under the macro).
- Reuses existing sub-module sub_word (one instance, 32-bit S-box).

## Test plan
- FIPS-197 App. A vector:
  - Stimulus: key_i = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Expect valid_o 21 cycles after accept.
  - Expect round_key_o[9] = ac7766f319fadc2128d12941575c006e.
  - Expect round_key_o[0] = 2b7e151628aed2a6abf7158809cf4f3c.
- Round-trip: 1000 random cipher keys through key_expansion, then feed its round_key_o[10] here. All 11 keys must match.
- valid_i pulsed with a different key_i during S_EXPAND of round 5: ignored, results unchanged, ready_o low.
- rst_n asserted at cycle 7 of a run:
  - Outputs zero, valid_o never pulses, ready_o = 1.
  - A fresh run afterward gives correct keys.
- valid_i held high across two runs with key changing at the second accept: second valid_o 22 cycles after first, with the second key's schedule.
- Macro defined:
  - round_key_o[1..9] = InvMixColumns of the FIPS round keys, checked against the model.
  - [0] and [10] are unchanged.
